// File: rtl/key_step_pulse_pkg.sv
// Shared constants and FSM state encoding for the key/step lab stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_step_pulse_pkg;

  // Debounce/auto-repeat FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    RELEASED = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } state_e;

  // Board clock and default timing, shared by every stage of the lab.
  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;  // 200 ms
  localparam int          DEF_CNT_W           = 25;

endpackage

// File: rtl/key_step_pulse_if.sv
// Groups the raw key input with the debounced step/level outputs.
// Latency: n/a (wiring only).
// Backpressure: none; step is a fire-and-forget enable pulse.
interface key_step_pulse_if;
  logic key_n;
  logic step;
  logic pressed;
  logic repeat_active;

  // Upstream side: drives the raw key, observes the pulses.
  modport master (output key_n, input step, pressed, repeat_active);
  // Debouncer side.
  modport slave  (input key_n, output step, pressed, repeat_active);
endinterface

// File: rtl/key_step_pulse_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clock edges from input change to q.
// Backpressure: none.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  // Next values: shift the raw level through the two stages.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // Synchronizer stages; reset to the idle (released) level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;
endmodule

// File: rtl/key_step_pulse.sv
// Debounces an active-low key and emits one-cycle step pulses with auto-repeat.
// Latency: first step DEBOUNCE_CYCLES+2 edges after key_n is first sampled low.
// Backpressure: none; step is a registered single-cycle enable.
module key_step_pulse
  import key_step_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int          CNT_W           = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  key_step_pulse_if.slave  kif
);

  // Terminal counts; every timer compare is an equality against one of these.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               HOLD_EN   = (HOLD_CYCLES != 0);

  logic key_sync;
  logic sp;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             step_d, step_q;
  logic             pressed_d, pressed_q;
  logic             repeat_active_d, repeat_active_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (kif.key_n),
    .q     (key_sync)
  );

  // Synchronized key, active-high.
  assign sp = ~key_sync;

  // FSM next state and timer; the timer is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        cnt_d = '0;
        if (sp) begin
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!sp) begin
          state_d = RELEASED;       // glitch shorter than the debounce window
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sp) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
          state_d = REPEAT;
          cnt_d   = '0;
          step_d  = 1'b1;
        end else if (HOLD_EN) begin
          cnt_d = cnt_q + CNT_ONE;  // frozen when repeat is disabled so it never wraps
        end
      end
      REPEAT: begin
        if (!sp) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REL_DB: begin
        if (sp) begin
          state_d = HELD;           // release bounce: hold timer restarts, no step
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Level outputs follow the next state so they change together with the step.
  always_comb begin
    pressed_d       = (state_d == HELD) || (state_d == REPEAT) || (state_d == REL_DB);
    repeat_active_d = (state_d == REPEAT);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= RELEASED;
      cnt_q           <= '0;
      step_q          <= 1'b0;
      pressed_q       <= 1'b0;
      repeat_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      step_q          <= step_d;
      pressed_q       <= pressed_d;
      repeat_active_q <= repeat_active_d;
    end
  end

  assign kif.step          = step_q;
  assign kif.pressed       = pressed_q;
  assign kif.repeat_active = repeat_active_q;

endmodule

// File: tb/tb_key_step_pulse.sv
// Directed bench for key_step_pulse with short debounce/hold/repeat timings.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_step_pulse;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  key_step_pulse_if kif();

  key_step_pulse #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3),
    .CNT_W           (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kif   (kif)
  );

  typedef struct {
    logic key_n;
    logic step;
    logic pressed;
    logic rep;
  } vec_t;

  vec_t vecs[45];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // Drive key_n for the next edge, then sample outputs 1 time unit after it.
  task automatic cyc(input string name, input int idx, input logic k,
                     input logic es, input logic ep, input logic er);
    kif.key_n = k;
    @(posedge clock);
    #1;
    chk({name, ".step"},    idx, kif.step,          es);
    chk({name, ".pressed"}, idx, kif.pressed,       ep);
    chk({name, ".repeat"},  idx, kif.repeat_active, er);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    kif.key_n = 1'b1;

    // Held press from edge 0, released (key_n=1 sampled) from edge 30.
    for (int i = 0; i < 45; i++) begin
      vecs[i].key_n   = (i >= 30);
      vecs[i].step    = (i == 6) || (i == 16) || (i == 19) || (i == 22) ||
                        (i == 25) || (i == 28) || (i == 31);
      vecs[i].pressed = (i >= 6) && (i <= 35);
      vecs[i].rep     = (i >= 16) && (i <= 31);
    end

    // Reset held low with the key released.
    for (int i = 0; i < 10; i++) cyc("reset", i, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc("idle", i, 1'b1, 1'b0, 1'b0, 1'b0);

    // Press, auto-repeat, then release from repeat.
    for (int i = 0; i < 45; i++)
      cyc("table", i, vecs[i].key_n, vecs[i].step, vecs[i].pressed, vecs[i].rep);

    // Three-cycle glitch: rejected.
    for (int i = 0; i < 12; i++) cyc("glitch", i, (i >= 3), 1'b0, 1'b0, 1'b0);

    // Fresh press, release bounce inside HELD, hold timer restarts at edge 13.
    for (int i = 0; i < 28; i++)
      cyc("bounce", i, (i == 9) || (i == 10),
          (i == 6) || (i == 23) || (i == 26), (i >= 6), (i >= 23));

    // Asynchronous reset mid-repeat with the key still held.
    #3;
    reset = 1'b0;
    #1;
    chk("arst.step",    0, kif.step,          1'b0);
    chk("arst.pressed", 0, kif.pressed,       1'b0);
    chk("arst.repeat",  0, kif.repeat_active, 1'b0);
    for (int i = 0; i < 2; i++) cyc("arst_hold", i, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 21; i++)
      cyc("after_rst", i, 1'b0, (i == 6) || (i == 16) || (i == 19), (i >= 6), (i >= 16));

    kif.key_n = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
